dtpu_vector_core: RTL and testbench
===================================

# dtpu_vector_core

Parametrised weight-stationary vector MAC engine for the dtpu fabric. It streams LANES-wide activation words from the input FIFO and matching weight words from weight-memory BRAM, and accumulates one product per lane per beat. At the end of a job it writes the LANES accumulators to the output FIFO. It sits beside the control unit as a self-sequenced core under the PS handshake (start/ready/done/continue/idle).

## Interface
Parameters:
- LANES, 4: parallel lanes per beat
- DATA_WIDTH, 8: element width per lane, activations and weights
- ACC_WIDTH, 20: accumulator and output word width; must be >= 2*DATA_WIDTH
- ADDR_WIDTH, 32: weight-memory address width, in words
- LEN_WIDTH, 16: width of the beat count

Ports:
- clk  in  1  single clock, all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- enable  in  1  global enable; low freezes all state and forces infifo_read, outfifo_write and wm_ce to 0
- cfg_len  in  LEN_WIDTH  beats per job, sampled at start
- cfg_base  in  ADDR_WIDTH  first weight word address, sampled at start
- cfg_signed  in  1  1 = two's-complement operands; sampled at start
- cs_start  in  1  job request
- cs_ready  out  1  one-cycle pulse on the cycle the last activation is popped
- cs_done  out  1  high in DONE state
- cs_continue  in  1  acknowledges done
- cs_idle  out  1  high in IDLE state
- infifo_dout  in  LANES*DATA_WIDTH  FWFT data, valid while infifo_is_empty=0; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- infifo_is_empty  in  1  1 = empty
- infifo_read  out  1  pop
- wm_ce  out  1  BRAM enable
- wm_address  out  ADDR_WIDTH  BRAM word address
- wm_dout  in  LANES*DATA_WIDTH  BRAM read data; 1-cycle latency; holds while wm_ce=0
- outfifo_din  out  ACC_WIDTH  result word
- outfifo_write  out  1  push
- outfifo_is_full  in  1  1 = full
- state  out  3  debug: IDLE=0, LOAD=1, DRAIN=2, WRITE=3, DONE=4

## Operation
- IDLE -> LOAD on cs_start=1 with enable=1:
  - latch cfg_len, cfg_base and cfg_signed
  - clear all accumulators, beat count and lane index
  - if cfg_len=0, go IDLE -> WRITE instead.
- LOAD, on each cycle with enable=1 and infifo_is_empty=0:
  - assert infifo_read, wm_ce=1 and wm_address=base+beat
  - register the activation word
  - increment beat
  - on the pop with beat=len-1: pulse cs_ready and go to DRAIN.
- An empty FIFO stalls the stream. No pop, no address advance, no MAC, wm_ce=0.
- MAC stage (the cycle after a pop):
  - acc[i] += act_reg[i]*wm_dout[i]
  - the product is sign-extended when signed, zero-extended when unsigned.
- DRAIN: performs the final MAC, then goes to WRITE.
- WRITE:
  - outfifo_din = acc[lane]
  - outfifo_write = enable & ~outfifo_is_full
  - lane advances only on a write
  - after the write of lane LANES-1, go to DONE.
- DONE: cs_done=1 until cs_continue=1, then go to IDLE. cs_start is ignored outside IDLE.
- wm_address = base+beat wraps modulo 2^ADDR_WIDTH.
- Accumulator overflow behaviour is set by the Configuration macro.
- Reset at any time, including mid-job:
  - next cycle state=IDLE and accumulators/counters = 0
  - cs_ready, cs_done, infifo_read, outfifo_write, wm_ce, wm_address and outfifo_din = 0
  - cs_idle = 1
  - in-flight data is discarded.

## Timing
- Stream throughput: 1 beat/cycle when the FIFO is non-empty and enable=1.
- Latency (cfg_len=N, no stalls), counting the start cycle as cycle 0:
  - first pop at cycle 1, last pop at cycle N
  - DRAIN at cycle N+1
  - first write at cycle N+2, last write at cycle N+1+LANES
  - cs_done from cycle N+2+LANES.
- cs_ready is coincident with the last infifo_read.
- outfifo_din is valid whenever state=WRITE and is stable under a full-FIFO stall.
- enable=0 for any number of cycles adds exactly that many cycles and changes no result. Pending BRAM data relies on wm_dout holding while wm_ce=0.
- cs_idle, cs_done and state are combinational from the state register.

## Configuration
- DTPU_ACC_SAT_EN defined: accumulators saturate.
  - signed: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]
  - unsigned: clamp to [0, 2^ACC_WIDTH-1]
  - overflow is detected on an ACC_WIDTH+1-bit sum.
- Undefined: accumulators wrap modulo 2^ACC_WIDTH.

## Test plan
- Unsigned baseline: LANES=4, len=3, all weights 2, all activations 3 -> four writes of 18, cs_ready on the 3rd pop, cs_done at cycle 9; cs_continue -> cs_idle=1.
- Signed: cfg_signed=1, len=2, lane0 weight 0xFF, activation 5 -> lane0 output 0xFFFF6 (-10, ACC_WIDTH=20); unsigned rerun of the same data -> 2550.
- FIFO gaps: assert empty for 2 cycles between every beat -> results identical to baseline; wm_address advances only on pops; wm_ce=0 during gaps.
- Output backpressure: full for 3 cycles after the lane1 write -> no writes, outfifo_din holds acc[2], then lanes 2 and 3 are written in order.
- Overflow: ACC_WIDTH=16, unsigned, len=2, 255*255 per beat -> 0xFFFF with DTPU_ACC_SAT_EN, 64514 without.
- Reset and edge cases:
  - aresetn=0 mid-LOAD -> all outputs zero, state=IDLE next cycle
  - cfg_len=0 -> four zero words, no pops
  - cfg_base=0xFFFFFFFF, len=2 -> addresses 0xFFFFFFFF, 0x0

Source files
------------

// File: rtl/dtpu_vector_core.sv
// dtpu_vector_core: weight-stationary LANES-wide MAC engine fed by an FWFT activation FIFO and weight BRAM.
// Build option DTPU_ACC_SAT_EN: saturating accumulators; when undefined, accumulators wrap.
module dtpu_vector_core #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [LEN_WIDTH-1:0]        cfg_len,
  input  logic [ADDR_WIDTH-1:0]       cfg_base,
  input  logic                        cfg_signed,
  input  logic                        cs_start,
  output logic                        cs_ready,
  output logic                        cs_done,
  input  logic                        cs_continue,
  output logic                        cs_idle,
  input  logic [LANES*DATA_WIDTH-1:0] infifo_dout,
  input  logic                        infifo_is_empty,
  output logic                        infifo_read,
  output logic                        wm_ce,
  output logic [ADDR_WIDTH-1:0]       wm_address,
  input  logic [LANES*DATA_WIDTH-1:0] wm_dout,
  output logic [ACC_WIDTH-1:0]        outfifo_din,
  output logic                        outfifo_write,
  input  logic                        outfifo_is_full,
  output logic [2:0]                  state
);
  // state | meaning
  // IDLE  | waiting for cs_start
  // LOAD  | popping activations and issuing weight reads
  // DRAIN | final MAC of the last beat
  // WRITE | pushing acc[lane] into the output FIFO
  // DONE  | waiting for cs_continue
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = ACC_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                      r_state;
  logic [LEN_WIDTH-1:0]        r_len;
  logic [LEN_WIDTH-1:0]        r_beat;
  logic [ADDR_WIDTH-1:0]       r_base;
  logic                        r_signed;
  logic [LANE_W-1:0]           r_lane;
  logic [LANES*DATA_WIDTH-1:0] r_act;
  logic                        r_mac_pend;
  logic [ACC_WIDTH-1:0]        r_acc [LANES];

  logic                        w_pop;
  logic                        w_last;
  logic                        w_write;
  logic [ACC_WIDTH-1:0]        w_acc_nxt [LANES];

  assign w_pop   = enable && (r_state == S_LOAD) && !infifo_is_empty;
  assign w_last  = (r_beat == (r_len - LEN_WIDTH'(1)));
  assign w_write = enable && (r_state == S_WRITE) && !outfifo_is_full;

  assign infifo_read   = w_pop;
  assign wm_ce         = w_pop;
  assign cs_ready      = w_pop && w_last;
  assign wm_address    = r_base + ADDR_WIDTH'(r_beat);
  assign outfifo_write = w_write;
  assign outfifo_din   = (r_state == S_WRITE) ? r_acc[r_lane] : '0;
  assign cs_idle       = (r_state == S_IDLE);
  assign cs_done       = (r_state == S_DONE);
  assign state         = r_state;

  // Operands are extended to the product width first so one multiplier serves both signednesses.
  always_comb begin
    logic [PROD_W-1:0] w_ae;
    logic [PROD_W-1:0] w_we;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_pext;
    logic [SUM_W-1:0]  w_aext;
    logic [SUM_W-1:0]  w_sum;
    w_ae   = '0;
    w_we   = '0;
    w_prod = '0;
    w_pext = '0;
    w_aext = '0;
    w_sum  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_acc_nxt[i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (r_signed) begin
        w_ae = {{DATA_WIDTH{r_act[i*DATA_WIDTH+DATA_WIDTH-1]}}, r_act[i*DATA_WIDTH +: DATA_WIDTH]};
        w_we = {{DATA_WIDTH{wm_dout[i*DATA_WIDTH+DATA_WIDTH-1]}}, wm_dout[i*DATA_WIDTH +: DATA_WIDTH]};
      end else begin
        w_ae = {{DATA_WIDTH{1'b0}}, r_act[i*DATA_WIDTH +: DATA_WIDTH]};
        w_we = {{DATA_WIDTH{1'b0}}, wm_dout[i*DATA_WIDTH +: DATA_WIDTH]};
      end
      w_prod = w_ae * w_we;
      w_pext = r_signed ? {{(SUM_W-PROD_W){w_prod[PROD_W-1]}}, w_prod}
                        : {{(SUM_W-PROD_W){1'b0}}, w_prod};
      w_aext = r_signed ? {r_acc[i][ACC_WIDTH-1], r_acc[i]} : {1'b0, r_acc[i]};
      w_sum  = w_aext + w_pext;
`ifdef DTPU_ACC_SAT_EN
      if (r_signed && (w_sum[SUM_W-1] != w_sum[SUM_W-2])) begin
        w_acc_nxt[i] = w_sum[SUM_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else if (!r_signed && w_sum[SUM_W-1]) begin
        w_acc_nxt[i] = '1;
      end else begin
        w_acc_nxt[i] = w_sum[ACC_WIDTH-1:0];
      end
`else
      w_acc_nxt[i] = w_sum[ACC_WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_beat     <= '0;
      r_base     <= '0;
      r_signed   <= 1'b0;
      r_lane     <= '0;
      r_act      <= '0;
      r_mac_pend <= 1'b0;
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else if (enable) begin
      // A pop this cycle re-arms the MAC for the next enabled cycle.
      r_mac_pend <= w_pop;
      if (r_mac_pend) begin
        for (int i = 0; i < LANES; i++) r_acc[i] <= w_acc_nxt[i];
      end
      if (w_pop) begin
        r_act  <= infifo_dout;
        r_beat <= r_beat + LEN_WIDTH'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (cs_start) begin
            r_len    <= cfg_len;
            r_base   <= cfg_base;
            r_signed <= cfg_signed;
            r_beat   <= '0;
            r_lane   <= '0;
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
            r_state  <= (cfg_len == '0) ? S_WRITE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_pop && w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_WRITE;
        S_WRITE: begin
          if (w_write) begin
            if (r_lane == LANE_W'(LANES - 1)) begin
              r_lane  <= '0;
              r_state <= S_DONE;
            end else begin
              r_lane <= r_lane + LANE_W'(1);
            end
          end
        end
        S_DONE: begin
          if (cs_continue) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtpu_vector_core.sv
// Scoreboard bench for dtpu_vector_core: directed jobs push expected results/addresses, a negedge monitor checks them.
// Expected overflow results follow DTPU_ACC_SAT_EN.
module tb_dtpu_vector_core;
  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int AW    = 20;
  localparam int ADW   = 32;
  localparam int LW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 aresetn, enable, cfg_signed, cs_start, cs_continue;
  logic                 cs_ready, cs_done, cs_idle;
  logic                 infifo_is_empty, infifo_read, wm_ce, outfifo_write, outfifo_is_full;
  logic [LW-1:0]        cfg_len;
  logic [ADW-1:0]       cfg_base, wm_address;
  logic [LANES*DW-1:0]  infifo_dout, wm_dout;
  logic [AW-1:0]        outfifo_din;
  logic [2:0]           state;

  dtpu_vector_core #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .cfg_len(cfg_len), .cfg_base(cfg_base), .cfg_signed(cfg_signed),
    .cs_start(cs_start), .cs_ready(cs_ready), .cs_done(cs_done),
    .cs_continue(cs_continue), .cs_idle(cs_idle),
    .infifo_dout(infifo_dout), .infifo_is_empty(infifo_is_empty), .infifo_read(infifo_read),
    .wm_ce(wm_ce), .wm_address(wm_address), .wm_dout(wm_dout),
    .outfifo_din(outfifo_din), .outfifo_write(outfifo_write), .outfifo_is_full(outfifo_is_full),
    .state(state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  act_q [$];
  logic [AW-1:0] exp_q [$];
  logic [ADW-1:0] addr_q [$];
  logic [31:0]  mem [64];

  int gap_len = 0, gap_cnt = 0, full_left = 0, wr_idx = 0;
  bit bp_mode = 0;
  logic rd_n = 1'b0, ce_n = 1'b0;
  logic [ADW-1:0] addr_n = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // FIFO, BRAM and output-full models; they react one step after the clock edge.
  always @(posedge clk) begin
    #1;
    if (rd_n) begin
      if (act_q.size() > 0) void'(act_q.pop_front());
      gap_cnt = gap_len;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    if (ce_n) wm_dout = mem[addr_n[5:0]];
    infifo_is_empty = (act_q.size() == 0) || (gap_cnt != 0);
    infifo_dout     = (act_q.size() > 0) ? act_q[0] : '0;
    if (full_left > 0) begin
      outfifo_is_full = 1'b1;
      full_left--;
    end else begin
      outfifo_is_full = 1'b0;
    end
  end

  // Monitor: sampled mid-cycle, pops the scoreboards.
  always @(negedge clk) begin
    rd_n   = infifo_read;
    ce_n   = wm_ce;
    addr_n = wm_address;
    if (aresetn) begin
      if (wm_ce) begin
        chk("ce_with_read", infifo_read, 1);
        if (addr_q.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("wm_address", wm_address, addr_q.pop_front());
      end
      if (state == 3'd1 && infifo_is_empty) chk("quiet_when_empty", {wm_ce, infifo_read}, 0);
      if (!enable) chk("quiet_when_disabled", {infifo_read, outfifo_write, wm_ce}, 0);
      if (outfifo_write) begin
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else chk("outfifo_din", outfifo_din, exp_q.pop_front());
        if (bp_mode && wr_idx == 1) full_left = 3;
        wr_idx++;
      end else if (state == 3'd3 && outfifo_is_full && exp_q.size() > 0) begin
        chk("din_hold_full", outfifo_din, exp_q[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [31:0] act, input int n, input logic [ADW-1:0] base);
    for (int i = 0; i < n; i++) begin
      act_q.push_back(act);
      addr_q.push_back(base + ADW'(i));
    end
  endtask

  task automatic push4(input int a0, input int a1, input int a2, input int a3);
    exp_q.push_back(AW'(a0));
    exp_q.push_back(AW'(a1));
    exp_q.push_back(AW'(a2));
    exp_q.push_back(AW'(a3));
  endtask

  task automatic run_job(input string tag, input int len, input logic [ADW-1:0] base, input logic sgn,
                         input int exp_done, input int exp_ready, input int en_off_at, input int en_off_len);
    int cyc, done_cyc, ready_cyc, ready_cnt;
    tick();
    cfg_len = LW'(len);
    cfg_base = base;
    cfg_signed = sgn;
    cs_start = 1'b1;
    wr_idx = 0;
    cyc = 0;
    done_cyc = -1;
    ready_cyc = -1;
    ready_cnt = 0;
    for (int k = 0; k < 300 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (cs_ready) begin
        ready_cnt++;
        ready_cyc = cyc;
      end
      if (cs_done) begin
        done_cyc = cyc;
      end else begin
        tick();
        cs_start = 1'b0;
        cyc++;
        if (cyc == en_off_at) enable = 1'b0;
        if (cyc == en_off_at + en_off_len) enable = 1'b1;
      end
    end
    cs_start = 1'b0;
    enable = 1'b1;
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_ready_count"}, ready_cnt, (exp_ready >= 0) ? 1 : 0);
    if (exp_ready >= 0) chk({tag, "_ready_cycle"}, ready_cyc, exp_ready);
    tick();
    cs_continue = 1'b1;
    tick();
    cs_continue = 1'b0;
    @(negedge clk);
    chk({tag, "_back_idle"}, {cs_idle, cs_done, state}, {1'b1, 1'b0, 3'd0});
    chk({tag, "_results_left"}, exp_q.size(), 0);
    chk({tag, "_addrs_left"}, addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; enable = 1'b1; cfg_len = '0; cfg_base = '0; cfg_signed = 1'b0;
    cs_start = 1'b0; cs_continue = 1'b0; infifo_is_empty = 1'b1; infifo_dout = '0;
    wm_dout = '0; outfifo_is_full = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 3; i++) mem[i] = 32'h02020202;
    for (int i = 8; i < 10; i++) mem[i] = 32'h007F80FF;
    for (int i = 16; i < 33; i++) mem[i] = 32'hFFFFFFFF;
    mem[63] = 32'h01010101;

    repeat (3) tick();
    @(negedge clk);
    chk("reset_status", {cs_idle, cs_done, cs_ready, state}, {1'b1, 1'b0, 1'b0, 3'd0});
    chk("reset_strobes", {infifo_read, outfifo_write, wm_ce}, 0);
    chk("reset_data", {wm_address, outfifo_din}, 0);
    tick();
    aresetn = 1'b1;

    // Unsigned baseline: 3 beats of 3*2 per lane.
    push_job(32'h03030303, 3, 0);
    push4(18, 18, 18, 18);
    run_job("baseline", 3, 0, 1'b0, 9, 3, -1, 0);

    // Signed mixed lanes, then the same data unsigned.
    push_job(32'hFF810205, 2, 8);
    push4('hFFFF6, 'hFFE00, 'hF81FE, 0);
    run_job("signed", 2, 8, 1'b1, 8, 2, -1, 0);
    push_job(32'hFF810205, 2, 8);
    push4(2550, 512, 32766, 0);
    run_job("unsigned", 2, 8, 1'b0, 8, 2, -1, 0);

    // Two empty cycles between beats.
    gap_len = 2;
    push_job(32'h03030303, 3, 0);
    push4(18, 18, 18, 18);
    run_job("gaps", 3, 0, 1'b0, 13, 7, -1, 0);
    gap_len = 0;

    // Output FIFO full for 3 cycles after the lane1 write.
    bp_mode = 1'b1;
    push_job(32'hFF810205, 2, 8);
    push4(2550, 512, 32766, 0);
    run_job("backpressure", 2, 8, 1'b0, 11, 2, -1, 0);
    bp_mode = 1'b0;

    // enable low for cycles 2..4 adds exactly 3 cycles.
    push_job(32'h03030303, 3, 0);
    push4(18, 18, 18, 18);
    run_job("enable_stall", 3, 0, 1'b0, 12, 6, 2, 3);

    // 17 beats of 255*255 overflows a 20-bit accumulator.
    push_job(32'hFFFFFFFF, 17, 16);
`ifdef DTPU_ACC_SAT_EN
    push4('hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF);
`else
    push4(56849, 56849, 56849, 56849);
`endif
    run_job("overflow", 17, 16, 1'b0, 23, 17, -1, 0);

    // Zero-length job: four zero words and the waiting activation stays put.
    act_q.push_back(32'h05050505);
    push4(0, 0, 0, 0);
    run_job("len0", 0, 0, 1'b0, 5, -1, -1, 0);
    chk("len0_no_pop", act_q.size(), 1);
    act_q.delete();
    tick();

    // Address wrap from 0xFFFFFFFF to 0.
    mem[0] = 32'h02020202;
    act_q.push_back(32'h04030201);
    act_q.push_back(32'h01010101);
    addr_q.push_back(32'hFFFFFFFF);
    addr_q.push_back(32'h00000000);
    push4(3, 4, 5, 6);
    run_job("wrap", 2, 32'hFFFFFFFF, 1'b0, 8, 2, -1, 0);

    // Reset in the middle of LOAD.
    tick();
    push_job(32'h03030303, 5, 0);
    tick();
    cfg_len = 16'd5; cfg_base = '0; cfg_signed = 1'b0; cs_start = 1'b1;
    tick();
    cs_start = 1'b0;
    tick();
    tick();
    aresetn = 1'b0;
    tick();
    @(negedge clk);
    chk("midreset_status", {cs_idle, cs_done, cs_ready, state}, {1'b1, 1'b0, 1'b0, 3'd0});
    chk("midreset_strobes", {infifo_read, outfifo_write, wm_ce}, 0);
    chk("midreset_data", {wm_address, outfifo_din}, 0);
    act_q.delete();
    addr_q.delete();
    tick();
    aresetn = 1'b1;
    tick();

    // Clean recovery after reset.
    push_job(32'h03030303, 3, 0);
    push4(18, 18, 18, 18);
    run_job("after_reset", 3, 0, 1'b0, 9, 3, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
